// File: rtl/traffic_phase_ctrl.sv
// Round-robin multi-approach traffic-light sequencer with an internal tick prescaler.
// Define TRAFFIC_PED_EN to add the pedestrian request input, walk lamp and WALK phase.
module traffic_phase_ctrl #(
   parameter int NUM_DIR   = 2,
   parameter int TICK_DIV  = 50_000_000,
   parameter int CNT_W     = 4,
   parameter int T_RED_CLR = 1,
   parameter int T_GREEN   = 4,
   parameter int T_YELLOW  = 2,
   parameter int T_WALK    = 3,
   localparam int DW       = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   output logic [NUM_DIR-1:0] red,
   output logic [NUM_DIR-1:0] yellow,
   output logic [NUM_DIR-1:0] green,
   output logic [DW-1:0]      active_dir,
   output logic               phase_done
`ifdef TRAFFIC_PED_EN
   ,
   input  logic               ped_req,
   output logic               walk
`endif
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      S_ALL_RED = 2'd0,
      S_GREEN   = 2'd1,
      S_YELLOW  = 2'd2,
      S_WALK    = 2'd3
   } state_t;

   state_t             r_state;
   logic [DW-1:0]      r_dir;
   logic [CNT_W-1:0]   r_timer;
   logic [PW-1:0]      r_presc;
   logic [NUM_DIR-1:0] r_red;
   logic [NUM_DIR-1:0] r_yellow;
   logic [NUM_DIR-1:0] r_green;
   logic               r_phase_done;
`ifdef TRAFFIC_PED_EN
   logic               r_ped;
   logic               r_walk;
`endif

   logic               w_tick;
   logic               w_illegal;
   logic               w_trans;
   logic               w_ped_pending;
   logic [CNT_W-1:0]   w_last;
   state_t             w_next_state;
   logic [DW-1:0]      w_next_dir;
   logic [NUM_DIR-1:0] w_next_sel;

`ifdef TRAFFIC_PED_EN
   assign w_ped_pending = r_ped;
`else
   assign w_ped_pending = 1'b0;
`endif

   assign w_tick = enable && (r_presc == PW'(TICK_DIV - 1));

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      w_last = '0;
      case (r_state)
         S_ALL_RED: w_last = CNT_W'(T_RED_CLR - 1);
         S_GREEN:   w_last = CNT_W'(T_GREEN - 1);
         S_YELLOW:  w_last = CNT_W'(T_YELLOW - 1);
         S_WALK:    w_last = CNT_W'(T_WALK - 1);
         default:   w_last = '0;
      endcase
   end

   always_comb begin
      w_illegal    = 1'b0;
      w_next_state = S_ALL_RED;
      w_next_dir   = r_dir;
      case (r_state)
         S_ALL_RED: w_next_state = w_ped_pending ? S_WALK : S_GREEN;
         S_GREEN:   w_next_state = S_YELLOW;
         S_YELLOW: begin
            w_next_state = S_ALL_RED;
            w_next_dir   = (r_dir == DW'(NUM_DIR - 1)) ? '0 : r_dir + 1'b1;
         end
`ifdef TRAFFIC_PED_EN
         S_WALK:    w_next_state = S_GREEN;
`endif
         // An unreachable encoding falls back to all-red clearance on the next enabled edge.
         default:   w_illegal = 1'b1;
      endcase
   end

   assign w_trans    = enable && (w_illegal || (w_tick && (r_timer == w_last)));
   assign w_next_sel = {{(NUM_DIR-1){1'b0}}, 1'b1} << w_next_dir;

   // Single FSM process: lamps are computed from the next state so they change on the transition edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is only ever written with non-blocking assignments.
      if (reset) begin
         r_state      <= S_ALL_RED;
         r_dir        <= '0;
         r_timer      <= '0;
         r_presc      <= '0;
         r_red        <= '1;
         r_yellow     <= '0;
         r_green      <= '0;
         r_phase_done <= 1'b0;
`ifdef TRAFFIC_PED_EN
         r_ped        <= 1'b0;
         r_walk       <= 1'b0;
`endif
      end else if (enable) begin
         r_presc      <= w_tick ? '0 : r_presc + 1'b1;
         r_phase_done <= w_trans;
         if (w_trans) begin
            r_state  <= w_next_state;
            r_dir    <= w_next_dir;
            r_timer  <= '0;
            r_red    <= (w_next_state == S_GREEN || w_next_state == S_YELLOW) ? ~w_next_sel : '1;
            r_green  <= (w_next_state == S_GREEN)  ? w_next_sel : '0;
            r_yellow <= (w_next_state == S_YELLOW) ? w_next_sel : '0;
         end else if (w_tick) begin
            r_timer  <= r_timer + 1'b1;
         end
`ifdef TRAFFIC_PED_EN
         // Entering WALK consumes the latched request; a press on that same cycle is kept.
         r_ped <= (r_ped && !(w_trans && w_next_state == S_WALK)) || ped_req;
         if (w_trans) r_walk <= (w_next_state == S_WALK);
`endif
      end else begin
         r_phase_done <= 1'b0;
      end
   end

   assign red        = r_red;
   assign yellow     = r_yellow;
   assign green      = r_green;
   assign active_dir = r_dir;
   assign phase_done = r_phase_done;
`ifdef TRAFFIC_PED_EN
   assign walk       = r_walk;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a phase/elapsed-cycle reference model predicts lamps
// and transition events; a monitor compares every cycle and pops one event per phase_done pulse.
module tb_traffic_phase_ctrl;
   localparam int NUM_DIR   = 2;
   localparam int TICK_DIV  = 2;
   localparam int CNT_W     = 4;
   localparam int T_RED_CLR = 1;
   localparam int T_GREEN   = 4;
   localparam int T_YELLOW  = 2;
   localparam int T_WALK    = 3;
   localparam int DW        = $clog2(NUM_DIR);
   localparam int HALF      = 5;
   localparam int LW        = 3 * NUM_DIR + 1;

   localparam int PH_CLR  = 0;
   localparam int PH_GO   = 1;
   localparam int PH_SLOW = 2;
   localparam int PH_WALK = 3;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               enable = 1'b0;
   logic               ped_req = 1'b0;
   logic [NUM_DIR-1:0] red;
   logic [NUM_DIR-1:0] yellow;
   logic [NUM_DIR-1:0] green;
   logic [DW-1:0]      active_dir;
   logic               phase_done;
   logic               walk;

   typedef struct {
      longint          t;
      int              dir;
      logic [LW-1:0]   lamps;
   } pd_exp_t;

   pd_exp_t sb_q[$];
   pd_exp_t mon_e;
   logic [LW-1:0] mon_act;

   int checks = 0;
   int failures = 0;

   int m_phase = PH_CLR;
   int m_dir = 0;
   int m_elapsed = 0;
   bit m_ped = 1'b0;
   bit m_pd = 1'b0;
   bit m_valid = 1'b0;

   traffic_phase_ctrl #(
      .NUM_DIR(NUM_DIR), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .T_RED_CLR(T_RED_CLR),
      .T_GREEN(T_GREEN), .T_YELLOW(T_YELLOW), .T_WALK(T_WALK)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .red(red),
      .yellow(yellow),
      .green(green),
      .active_dir(active_dir),
      .phase_done(phase_done)
`ifdef TRAFFIC_PED_EN
      ,
      .ped_req(ped_req),
      .walk(walk)
`endif
   );

`ifndef TRAFFIC_PED_EN
   assign walk = 1'b0;
`endif

   always #HALF clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int phase_ticks(input int ph);
      case (ph)
         PH_CLR:  return T_RED_CLR;
         PH_GO:   return T_GREEN;
         PH_SLOW: return T_YELLOW;
         default: return T_WALK;
      endcase
   endfunction

   function automatic logic [LW-1:0] lamps_of(input int ph, input int d);
      logic [NUM_DIR-1:0] r, y, g;
      r = '1;
      y = '0;
      g = '0;
      if (ph == PH_GO)   begin g[d] = 1'b1; r[d] = 1'b0; end
      if (ph == PH_SLOW) begin y[d] = 1'b1; r[d] = 1'b0; end
      return {(ph == PH_WALK), r, y, g};
   endfunction

   function automatic bit invariant_ok();
      int lit_dirs;
      lit_dirs = 0;
      for (int i = 0; i < NUM_DIR; i++) begin
         if ((int'(red[i]) + int'(yellow[i]) + int'(green[i])) != 1) return 1'b0;
         if (!red[i]) lit_dirs++;
      end
      return (lit_dirs <= 1);
   endfunction

   // Predicts the effect of the coming posedge from the inputs just driven.
   task automatic model_update();
      int nph;
      int ndir;
      bit latch;
      pd_exp_t e;
      m_valid = 1'b1;
      m_pd = 1'b0;
      if (reset) begin
         m_phase = PH_CLR;
         m_dir = 0;
         m_elapsed = 0;
         m_ped = 1'b0;
      end else if (enable) begin
         m_elapsed++;
         latch = m_ped;
         m_ped = m_ped | ped_req;
         if (m_elapsed == phase_ticks(m_phase) * TICK_DIV) begin
            ndir = m_dir;
            case (m_phase)
               PH_CLR:  nph = latch ? PH_WALK : PH_GO;
               PH_GO:   nph = PH_SLOW;
               PH_SLOW: begin nph = PH_CLR; ndir = (m_dir + 1) % NUM_DIR; end
               default: nph = PH_GO;
            endcase
            if (nph == PH_WALK) m_ped = ped_req;
            m_phase = nph;
            m_dir = ndir;
            m_elapsed = 0;
            m_pd = 1'b1;
            e.t = $time + HALF;
            e.dir = ndir;
            e.lamps = lamps_of(nph, ndir);
            sb_q.push_back(e);
         end
      end
   endtask

   // Drive on the falling edge, return shortly after the rising edge that applied the inputs.
   task automatic step(input logic r, input logic en, input logic p);
      @(negedge clk);
      reset = r;
      enable = en;
`ifdef TRAFFIC_PED_EN
      ped_req = p;
`else
      ped_req = 1'b0 & p;
`endif
      model_update();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         mon_act = {walk, red, yellow, green};
         check("lamps", mon_act, lamps_of(m_phase, m_dir));
         check("active_dir", active_dir, m_dir);
         check("phase_done", phase_done, m_pd);
         check("lamp_invariant", invariant_ok(), 1);
         if (phase_done === 1'b1) begin
            check("sb_event_expected", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               check("pd_time", $time - 1, mon_e.t);
               check("pd_dir", active_dir, mon_e.dir);
               check("pd_lamps", mon_act, mon_e.lamps);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int cnt;
      int pd_cnt;
      bit saw_wrap;
      bit frozen_done;
      logic [DW-1:0] prev_dir;
      logic [NUM_DIR-1:0] er, eg, ey;

      // Reset release sequence.
      step(1'b1, 1'b1, 1'b0);
      check("t1_reset_red", red, 2'b11);
      check("t1_reset_dir", active_dir, 0);
      check("t1_reset_pd", phase_done, 0);
      for (int k = 1; k <= 16; k++) begin
         step(1'b0, 1'b1, 1'b0);
         if (k < 2 || k >= 14 && k < 16) begin er = 2'b11; eg = 2'b00; ey = 2'b00; end
         else if (k < 10)                begin er = 2'b10; eg = 2'b01; ey = 2'b00; end
         else if (k < 14)                begin er = 2'b10; eg = 2'b00; ey = 2'b01; end
         else                            begin er = 2'b01; eg = 2'b10; ey = 2'b00; end
         check("t1_red", red, er);
         check("t1_green", green, eg);
         check("t1_yellow", yellow, ey);
      end
      check("t1_dir_after", active_dir, 1);

      // Two full rotations from reset.
      step(1'b1, 1'b1, 1'b0);
      pd_cnt = 0;
      saw_wrap = 1'b0;
      prev_dir = active_dir;
      for (int k = 1; k <= 56; k++) begin
         step(1'b0, 1'b1, 1'b0);
         if (phase_done) pd_cnt++;
         if (prev_dir == 1 && active_dir == 0) saw_wrap = 1'b1;
         prev_dir = active_dir;
      end
      check("t2_pd_count", pd_cnt, 12);
      check("t2_dir_wrap", saw_wrap, 1);

      // Freeze mid-green on a partial prescaler count.
      step(1'b1, 1'b1, 1'b0);
      guard = 0;
      while (green == 0 && guard < 20) begin step(1'b0, 1'b1, 1'b0); guard++; end
      check("t3_green_seen", green, 2'b01);
      cnt = 0;
      frozen_done = 1'b0;
      guard = 0;
      while (yellow == 0 && guard < 60) begin
         if (cnt == 3 && !frozen_done) begin
            for (int j = 0; j < 5; j++) begin
               step(1'b0, 1'b0, 1'b0);
               check("t3_freeze_green", green, 2'b01);
               check("t3_freeze_pd", phase_done, 0);
            end
            frozen_done = 1'b1;
         end else begin
            step(1'b0, 1'b1, 1'b0);
            cnt++;
         end
         guard++;
      end
      check("t3_green_enabled_len", cnt, 8);

      // Reset in the middle of yellow for approach 1.
      step(1'b1, 1'b1, 1'b0);
      guard = 0;
      while (!(yellow != 0 && active_dir == 1) && guard < 60) begin step(1'b0, 1'b1, 1'b0); guard++; end
      check("t4_in_yellow1", yellow, 2'b10);
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("t4_red", red, 2'b11);
      check("t4_dir", active_dir, 0);
      check("t4_pd", phase_done, 0);
      step(1'b0, 1'b1, 1'b0);
      check("t4_red_after", red, 2'b11);

`ifdef TRAFFIC_PED_EN
      // Single pedestrian press during green0.
      step(1'b1, 1'b1, 1'b0);
      guard = 0;
      while (green != 2'b01 && guard < 20) begin step(1'b0, 1'b1, 1'b0); guard++; end
      step(1'b0, 1'b1, 1'b1);
      guard = 0;
      while (walk == 0 && guard < 40) begin step(1'b0, 1'b1, 1'b0); guard++; end
      check("t5_walk_seen", walk, 1);
      check("t5_walk_dir", active_dir, 1);
      cnt = 0;
      guard = 0;
      while (walk && guard < 20) begin
         check("t5_walk_red", red, 2'b11);
         cnt++;
         guard++;
         step(1'b0, 1'b1, 1'b0);
      end
      check("t5_walk_len", cnt, 6);
      check("t5_green_after", green, 2'b10);

      // Request held high: a walk precedes every green; none without a request.
      step(1'b1, 1'b1, 1'b1);
      saw_wrap = 1'b0;
      cnt = 0;
      begin
         logic prev_walk, prev_green_any;
         prev_walk = walk;
         prev_green_any = (green != 0);
         for (int k = 1; k <= 100; k++) begin
            step(1'b0, 1'b1, 1'b1);
            if (green != 0 && !prev_green_any) begin
               cnt++;
               check("t6_walk_before_green", prev_walk, 1);
            end
            prev_walk = walk;
            prev_green_any = (green != 0);
         end
      end
      check("t6_greens_seen", cnt > 2, 1);
      step(1'b1, 1'b1, 1'b0);
      saw_wrap = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         step(1'b0, 1'b1, 1'b0);
         if (walk) saw_wrap = 1'b1;
      end
      check("t6_no_walk_without_req", saw_wrap, 0);
`endif

      // Randomised run: sporadic freezes, rare resets, occasional presses.
      step(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 2500; k++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
      end
      step(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
